// File: rtl/floo_vc_link_cut_pkg.sv
// Shared helpers and default types for the VC link cut stage.
package floo_vc_link_cut_pkg;

    // Index width for a range of num values, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
    endfunction

    // Flit type used when the network package does not override it.
    typedef logic [63:0] flit64_t;

endpackage

// File: rtl/floo_vc_link_cut_fifo.sv
// Per-VC flit FIFO; full/empty/head derive from registered state only.
module floo_vc_link_cut_fifo
    import floo_vc_link_cut_pkg::*;
#(
    parameter int unsigned Depth  = 2,
    parameter type         flit_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  flit_t data_i,
    input  logic  pop_i,
    output flit_t data_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = idx_width(Depth + 1);

    flit_t           mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    // Pointer and fill-count update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CntW'(push_i) - CntW'(pop_i);
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Flit storage; contents are only meaningful where cnt says so.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/floo_vc_link_cut.sv
// Registered timing cut for a VC-multiplexed link: per-VC FIFOs, round-robin
// re-arbitration, and a load-on-handshake output register.
module floo_vc_link_cut
    import floo_vc_link_cut_pkg::*;
#(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned Depth           = 2,
    parameter type         flit_t          = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumVirtChannels-1:0] valid_i,
    output logic [NumVirtChannels-1:0] ready_o,
    input  flit_t                      data_i,
    output logic [NumVirtChannels-1:0] valid_o,
    input  logic [NumVirtChannels-1:0] ready_i,
    output flit_t                      data_o
);
    localparam int unsigned VcW = idx_width(NumVirtChannels);

    logic [NumVirtChannels-1:0] push, pop, full, empty;
    flit_t                      head [NumVirtChannels];

    logic           out_valid_q, out_valid_d;
    logic [VcW-1:0] out_vc_q, out_vc_d;
    flit_t          out_data_q, out_data_d;
    logic [VcW-1:0] rr_q, rr_d;
    logic           out_free;
    logic [VcW:0]   pick;

    // First requester at or after ptr, wrapping; MSB flags a valid pick.
    function automatic logic [VcW:0] rr_pick(input logic [NumVirtChannels-1:0] req,
                                             input logic [VcW-1:0] ptr);
        logic [VcW:0] res;
        int unsigned  cand;
        res = '0;
        for (int unsigned off = 0; off < NumVirtChannels; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= NumVirtChannels) cand = cand - NumVirtChannels;
            if (!res[VcW] && req[VcW'(cand)]) res = {1'b1, VcW'(cand)};
        end
        return res;
    endfunction

    function automatic logic [VcW-1:0] vc_inc(input logic [VcW-1:0] vc);
        return (32'(vc) == NumVirtChannels - 1) ? '0 : vc + VcW'(1);
    endfunction

    for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
        floo_vc_link_cut_fifo #(
            .Depth  (Depth),
            .flit_t (flit_t)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push[v]),
            .data_i  (data_i),
            .pop_i   (pop[v]),
            .data_o  (head[v]),
            .full_o  (full[v]),
            .empty_o (empty[v])
        );
    end

    assign ready_o  = ~full;
    assign push     = valid_i & ready_o;
    assign out_free = !out_valid_q || ready_i[out_vc_q];
    assign pick     = rr_pick(~empty, rr_q);

    // Arbitration and output-register next state; grant only when free.
    always_comb begin
        pop         = '0;
        out_valid_d = out_valid_q;
        out_vc_d    = out_vc_q;
        out_data_d  = out_data_q;
        rr_d        = rr_q;
        if (out_free) begin
            out_valid_d = pick[VcW];
            if (pick[VcW]) begin
                pop[pick[VcW-1:0]] = 1'b1;
                out_vc_d           = pick[VcW-1:0];
                out_data_d         = head[pick[VcW-1:0]];
                rr_d               = vc_inc(pick[VcW-1:0]);
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            out_data_q  <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_vc_q    <= out_vc_d;
            out_data_q  <= out_data_d;
            rr_q        <= rr_d;
        end
    end

    assign valid_o = out_valid_q ? (NumVirtChannels'(1) << out_vc_q) : '0;
    assign data_o  = out_data_q;

`ifndef SYNTHESIS
    for (genvar v = 0; v < NumVirtChannels; v++) begin : g_sva
        a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            valid_o[v] && !ready_i[v] |=> $stable(valid_o) && $stable(data_o));
        a_in_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            valid_i[v] && !ready_o[v] |=> valid_i[v]);
    end
    a_in_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(valid_i));
`endif

endmodule

// File: tb/tb_floo_vc_link_cut.sv
// Directed bench for floo_vc_link_cut with NumVirtChannels=2, Depth=2, 64-bit flits.
module tb_floo_vc_link_cut;
    import floo_vc_link_cut_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  valid_i, ready_o, valid_o, ready_i;
    flit64_t     data_i, data_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Inputs are held for one clock; expectations are outputs after that clock.
    typedef struct {
        logic [1:0]  vld;
        logic [63:0] dat;
        logic [1:0]  rdy;
        logic [1:0]  exp_vld;
        logic [1:0]  exp_rdy;
        logic [63:0] exp_dat;
        logic        chk_dat;
    } vec_t;

    vec_t vecs[$];

    floo_vc_link_cut #(
        .NumVirtChannels (2),
        .Depth           (2),
        .flit_t          (flit64_t)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic add(input logic [1:0] vld, input logic [63:0] dat, input logic [1:0] rdy,
                       input logic [1:0] ev, input logic [1:0] er, input logic [63:0] ed,
                       input logic cd);
        vec_t v;
        v = '{vld, dat, rdy, ev, er, ed, cd};
        vecs.push_back(v);
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            valid_i = vecs[i].vld;
            data_i  = vecs[i].dat;
            ready_i = vecs[i].rdy;
            step();
            check($sformatf("%s[%0d] valid_o", tag, i), 64'(valid_o), 64'(vecs[i].exp_vld));
            check($sformatf("%s[%0d] ready_o", tag, i), 64'(ready_o), 64'(vecs[i].exp_rdy));
            if (vecs[i].chk_dat)
                check($sformatf("%s[%0d] data_o", tag, i), data_o, vecs[i].exp_dat);
        end
        vecs.delete();
        valid_i = '0;
        data_i  = '0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        valid_i = '0;
        ready_i = '0;
        data_i  = '0;

        // Reset held for three cycles, then released.
        #1;
        repeat (3) step();
        check("rst valid_o", 64'(valid_o), 64'(2'b00));
        check("rst data_o", data_o, 64'h0);
        check("rst ready_o", 64'(ready_o), 64'(2'b11));
        rst_ni = 1'b1;
        repeat (2) begin
            step();
            check("post-rst valid_o", 64'(valid_o), 64'(2'b00));
            check("post-rst ready_o", 64'(ready_o), 64'(2'b11));
        end

        // Single flit on VC1: visible two cycles after the push, gone the next.
        add(2'b10, 64'hA5, 2'b11, 2'b00, 2'b11, 64'h0,  1'b0);
        add(2'b00, 64'h0,  2'b11, 2'b10, 2'b11, 64'hA5, 1'b1);
        add(2'b00, 64'h0,  2'b11, 2'b00, 2'b11, 64'h0,  1'b0);
        run_table("single");

        // Streaming ten flits on VC0 without bubbles.
        ready_i = 2'b11;
        for (int j = 0; j < 12; j++) begin
            valid_i = (j < 10) ? 2'b01 : 2'b00;
            data_i  = (j < 10) ? 64'(j) : 64'h0;
            step();
            check($sformatf("stream[%0d] ready_o0", j), 64'(ready_o[0]), 64'h1);
            if (j >= 1 && j <= 10) begin
                check($sformatf("stream[%0d] valid_o", j), 64'(valid_o), 64'(2'b01));
                check($sformatf("stream[%0d] data_o", j), data_o, 64'(j - 1));
            end else begin
                check($sformatf("stream[%0d] valid_o", j), 64'(valid_o), 64'(2'b00));
            end
        end
        valid_i = '0;

        // Backpressure on VC0: three accepted, fourth held until ready rises.
        add(2'b01, 64'h10, 2'b00, 2'b00, 2'b11, 64'h0,  1'b0);
        add(2'b01, 64'h11, 2'b00, 2'b01, 2'b11, 64'h10, 1'b1);
        add(2'b01, 64'h12, 2'b00, 2'b01, 2'b10, 64'h10, 1'b1);
        add(2'b01, 64'h13, 2'b00, 2'b01, 2'b10, 64'h10, 1'b1);
        add(2'b01, 64'h13, 2'b01, 2'b01, 2'b11, 64'h11, 1'b1);
        add(2'b01, 64'h13, 2'b01, 2'b01, 2'b11, 64'h12, 1'b1);
        add(2'b00, 64'h0,  2'b01, 2'b01, 2'b11, 64'h13, 1'b1);
        add(2'b00, 64'h0,  2'b01, 2'b00, 2'b11, 64'h0,  1'b0);
        run_table("bp");

        // Round robin between two preloaded VCs.
        add(2'b01, 64'hA0, 2'b00, 2'b00, 2'b11, 64'h0,  1'b0);
        add(2'b01, 64'hA1, 2'b00, 2'b01, 2'b11, 64'hA0, 1'b1);
        add(2'b10, 64'hB0, 2'b00, 2'b01, 2'b11, 64'hA0, 1'b1);
        add(2'b10, 64'hB1, 2'b00, 2'b01, 2'b01, 64'hA0, 1'b1);
        add(2'b00, 64'h0,  2'b11, 2'b10, 2'b11, 64'hB0, 1'b1);
        add(2'b00, 64'h0,  2'b11, 2'b01, 2'b11, 64'hA1, 1'b1);
        add(2'b00, 64'h0,  2'b11, 2'b10, 2'b11, 64'hB1, 1'b1);
        add(2'b00, 64'h0,  2'b11, 2'b00, 2'b11, 64'h0,  1'b0);
        run_table("rr");

        // Stall VC1 with a second flit buffered, then reset mid-operation.
        ready_i = 2'b01;
        valid_i = 2'b10;
        data_i  = 64'hC1;
        step();
        check("stall load valid_o", 64'(valid_o), 64'(2'b00));
        data_i = 64'hC2;
        step();
        valid_i = '0;
        data_i  = '0;
        check("stall first valid_o", 64'(valid_o), 64'(2'b10));
        check("stall first data_o", data_o, 64'hC1);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("stall[%0d] valid_o", k), 64'(valid_o), 64'(2'b10));
            check($sformatf("stall[%0d] data_o", k), data_o, 64'hC1);
            check($sformatf("stall[%0d] ready_o", k), 64'(ready_o), 64'(2'b11));
        end
        rst_ni = 1'b0;
        #1;
        check("async rst valid_o", 64'(valid_o), 64'(2'b00));
        check("async rst data_o", data_o, 64'h0);
        check("async rst ready_o", 64'(ready_o), 64'(2'b11));
        repeat (2) step();
        rst_ni  = 1'b1;
        ready_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("after rst[%0d] valid_o", k), 64'(valid_o), 64'(2'b00));
            check($sformatf("after rst[%0d] data_o", k), data_o, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
